// File: rtl/midi_voice_allocator.sv
// MIDI note-on/note-off parser with running status feeding a small voice pool.
// Define VOICE_STEAL_EN to steal the oldest voice when the pool is full (default: drop the note).
module midi_voice_allocator #(
  parameter int         NUM_VOICES   = 8,
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter int         NOTE_LO      = 21,
  parameter int         NOTE_HI      = 108
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES*7-1:0] voice_key,
  output logic [NUM_VOICES*7-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [3:0]              active_count,
  output logic                    note_dropped
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, COMMIT} state_t;

  localparam logic [6:0] NOTE_LO_7 = 7'(NOTE_LO);
  localparam logic [6:0] NOTE_HI_7 = 7'(NOTE_HI);

  state_t                state_q, state_d;
  logic                  is_on_q, is_on_d;
  logic [6:0]            note_q, note_d, vel_q, vel_d;
  logic [NUM_VOICES-1:0] active_q, active_d, trig_q, trig_d;
  logic [6:0]            key_q [NUM_VOICES];
  logic [6:0]            key_d [NUM_VOICES];
  logic [6:0]            velo_q [NUM_VOICES];
  logic [6:0]            velo_d [NUM_VOICES];
  logic                  dropped_q, dropped_d;
  logic [3:0]            count_q, count_d;

  logic [6:0]            key_idx;
  logic                  in_range, note_on, accept;
  logic [NUM_VOICES-1:0] hit_oh, free_oh, tgt_oh;
  logic                  found_hit, found_free;
  logic [3:0]            cnt;

`ifdef VOICE_STEAL_EN
  localparam logic [2:0] AGE_MAX = 3'(NUM_VOICES - 1);
  logic [2:0]            age_q [NUM_VOICES];
  logic [2:0]            age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] old_oh;
  logic [2:0]            old_age;
`endif

  assign accept     = byte_valid && (state_q != COMMIT);
  assign byte_ready = (state_q != COMMIT);
  assign key_idx    = note_q - NOTE_LO_7;
  assign in_range   = (note_q >= NOTE_LO_7) && (note_q <= NOTE_HI_7);
  assign note_on    = is_on_q && (vel_q != 7'd0);

  always_comb begin
    state_d = state_q;
    is_on_d = is_on_q;
    note_d  = note_q;
    vel_d   = vel_q;
    if (state_q == COMMIT) begin
      state_d = DATA1;
    end else if (accept) begin
      if (byte_data[7]) begin
        // Realtime bytes (0xF8-0xFF) fall through untouched.
        if (byte_data < 8'hF8) begin
          if ((byte_data[3:0] == MIDI_CHANNEL) &&
              ((byte_data[7:4] == 4'h9) || (byte_data[7:4] == 4'h8))) begin
            is_on_d = byte_data[4];
            state_d = DATA1;
          end else begin
            state_d = IDLE;
          end
        end
      end else begin
        case (state_q)
          DATA1: begin note_d = byte_data[6:0]; state_d = DATA2;  end
          DATA2: begin vel_d  = byte_data[6:0]; state_d = COMMIT; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    active_d   = active_q;
    trig_d     = '0;
    dropped_d  = 1'b0;
    hit_oh     = '0;
    free_oh    = '0;
    tgt_oh     = '0;
    found_hit  = 1'b0;
    found_free = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_d[v]  = key_q[v];
      velo_d[v] = velo_q[v];
      if (!found_hit && active_q[v] && (key_q[v] == key_idx)) begin
        hit_oh[v] = 1'b1;
        found_hit = 1'b1;
      end
      if (!found_free && !active_q[v]) begin
        free_oh[v] = 1'b1;
        found_free = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    old_oh    = '0;
    old_oh[0] = 1'b1;
    old_age   = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_oh    = '0;
        old_oh[v] = 1'b1;
        old_age   = age_q[v];
      end
    end
`endif
    if ((state_q == COMMIT) && in_range) begin
      if (note_on) begin
        if (found_hit) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (hit_oh[v]) begin
              velo_d[v] = vel_q;
              trig_d[v] = 1'b1;
            end
          end
        end else if (found_free) begin
          tgt_oh = free_oh;
        end else begin
`ifdef VOICE_STEAL_EN
          tgt_oh = old_oh;
`else
          dropped_d = 1'b1;
`endif
        end
      end else begin
        // Release keeps key/velocity so the envelope can finish its tail.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (active_q[v] && (key_q[v] == key_idx)) active_d[v] = 1'b0;
        end
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (tgt_oh[v]) begin
        key_d[v]    = key_idx;
        velo_d[v]   = vel_q;
        active_d[v] = 1'b1;
        trig_d[v]   = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    for (int v = 0; v < NUM_VOICES; v++) begin
      age_d[v] = age_q[v];
      if (|tgt_oh) begin
        if (tgt_oh[v]) age_d[v] = 3'd0;
        else if (active_q[v] && (age_q[v] != AGE_MAX)) age_d[v] = age_q[v] + 3'd1;
      end
    end
`endif
  end

  always_comb begin
    cnt = 4'd0;
    for (int v = 0; v < NUM_VOICES; v++) cnt = cnt + {3'd0, active_q[v]};
    count_d = (cnt == 4'd0) ? 4'd1 : cnt;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      is_on_q   <= 1'b0;
      note_q    <= '0;
      vel_q     <= '0;
      active_q  <= '0;
      trig_q    <= '0;
      dropped_q <= 1'b0;
      count_q   <= 4'd1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]  <= '0;
        velo_q[v] <= '0;
`ifdef VOICE_STEAL_EN
        age_q[v]  <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      is_on_q   <= is_on_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      active_q  <= active_d;
      trig_q    <= trig_d;
      dropped_q <= dropped_d;
      count_q   <= count_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]  <= key_d[v];
        velo_q[v] <= velo_d[v];
`ifdef VOICE_STEAL_EN
        age_q[v]  <= age_d[v];
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_key[7*g +: 7]      = key_q[g];
    assign voice_velocity[7*g +: 7] = velo_q[g];
  end

  assign voice_active = active_q;
  assign voice_trig   = trig_q;
  assign active_count = count_q;
  assign note_dropped = dropped_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator: message-level voice model checked every cycle,
// plus literal end-of-scenario expectations.
module tb_midi_voice_allocator;

  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [NV-1:0] voice_active;
  logic [NV*7-1:0] voice_key;
  logic [NV*7-1:0] voice_velocity;
  logic [NV-1:0] voice_trig;
  logic [3:0]    active_count;
  logic          note_dropped;

  midi_voice_allocator dut (
    .clk(clk), .nreset(nreset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .voice_active(voice_active), .voice_key(voice_key),
    .voice_velocity(voice_velocity), .voice_trig(voice_trig),
    .active_count(active_count), .note_dropped(note_dropped)
  );

  always #5 clk = ~clk;

  // Message-level model: parser flags plus per-voice arrays.
  bit       m_status, m_expect_vel, m_on, m_commit, m_pend;
  int       m_note, m_vel;
  bit       m_active [NV];
  int       m_key [NV];
  int       m_velo [NV];
  int       m_age [NV];
  bit [NV-1:0] exp_trig;
  bit       exp_drop;
  int       exp_count;
  int       m_pop, m_tgt, m_hit, m_k, m_best;
  bit       m_on_eff;

  always @(posedge clk) begin
    if (!nreset) begin
      m_status = 0; m_expect_vel = 0; m_on = 0; m_commit = 0; m_pend = 0;
      exp_trig = '0; exp_drop = 0; exp_count = 1;
      for (int v = 0; v < NV; v++) begin
        m_active[v] = 0; m_key[v] = 0; m_velo[v] = 0; m_age[v] = 0;
      end
    end else begin
      m_pop = 0;
      for (int v = 0; v < NV; v++) m_pop += int'(m_active[v]);
      exp_trig = '0;
      exp_drop = 0;
      if (m_pend) begin
        m_pend = 0;
        m_commit = 0;
        if (m_note >= 21 && m_note <= 108) begin
          m_k = m_note - 21;
          m_on_eff = m_on && (m_vel != 0);
          if (m_on_eff) begin
            m_hit = -1; m_tgt = -1;
            for (int v = NV - 1; v >= 0; v--) begin
              if (m_active[v] && m_key[v] == m_k) m_hit = v;
              if (!m_active[v]) m_tgt = v;
            end
            if (m_hit >= 0) begin
              m_velo[m_hit] = m_vel;
              exp_trig[m_hit] = 1;
            end else begin
`ifdef VOICE_STEAL_EN
              if (m_tgt < 0) begin
                m_best = -1;
                for (int v = 0; v < NV; v++)
                  if (m_age[v] > m_best) begin m_best = m_age[v]; m_tgt = v; end
              end
`else
              if (m_tgt < 0) exp_drop = 1;
`endif
              if (m_tgt >= 0) begin
                for (int v = 0; v < NV; v++)
                  if (v != m_tgt && m_active[v] && m_age[v] < NV - 1) m_age[v]++;
                m_age[m_tgt] = 0;
                m_key[m_tgt] = m_k;
                m_velo[m_tgt] = m_vel;
                m_active[m_tgt] = 1;
                exp_trig[m_tgt] = 1;
              end
            end
          end else begin
            for (int v = 0; v < NV; v++)
              if (m_active[v] && m_key[v] == m_k) m_active[v] = 0;
          end
        end
      end else if (byte_valid && !m_commit) begin
        if (byte_data >= 8'hF8) begin
        end else if (byte_data[7]) begin
          if (byte_data == 8'h90 || byte_data == 8'h80) begin
            m_status = 1; m_on = byte_data[4]; m_expect_vel = 0;
          end else begin
            m_status = 0;
          end
        end else if (m_status) begin
          if (!m_expect_vel) begin
            m_note = int'(byte_data); m_expect_vel = 1;
          end else begin
            m_vel = int'(byte_data); m_expect_vel = 0; m_pend = 1; m_commit = 1;
          end
        end
      end
      exp_count = (m_pop == 0) ? 1 : m_pop;
    end
  end

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 0;
  int  trig_cnt = 0;
  int  drop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NV*7-1:0] ek, ev;
    logic [NV-1:0]   ea;
    for (int v = 0; v < NV; v++) begin
      ek[7*v +: 7] = 7'(m_key[v]);
      ev[7*v +: 7] = 7'(m_velo[v]);
      ea[v] = m_active[v];
    end
    chk("byte_ready", 64'(byte_ready), 64'(!m_commit));
    chk("voice_active", 64'(voice_active), 64'(ea));
    chk("voice_key", 64'(voice_key), 64'(ek));
    chk("voice_velocity", 64'(voice_velocity), 64'(ev));
    chk("voice_trig", 64'(voice_trig), 64'(exp_trig));
    chk("active_count", 64'(active_count), 64'(exp_count));
    chk("note_dropped", 64'(note_dropped), 64'(exp_drop));
  endtask

  task automatic step();
    @(negedge clk);
    if (cmp_en) begin
      compare_all();
      trig_cnt += $countones(voice_trig);
      drop_cnt += int'(note_dropped);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 10) begin step(); n++; end
    if (n >= 10) chk("ready_timeout", 64'(0), 64'(1));
    step();
  endtask

  task automatic idle(input int k);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (k) step();
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    byte_valid = 1'b0;
    step();
    cmp_en = 1;
    step();
    nreset = 1'b1;
  endtask

  int t0, d0;
  logic [7:0] b;

  initial begin
    nreset = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    step();
    do_reset();
    chk("rst_ready", 64'(byte_ready), 64'(1));
    chk("rst_count", 64'(active_count), 64'(1));
    chk("rst_active", 64'(voice_active), 64'(0));

    // first note-on and running-status second note
    t0 = trig_cnt;
    send(8'h90); send(8'h3C); send(8'h64); idle(4);
    chk("t1_active", 64'(voice_active), 64'h01);
    chk("t1_key0", 64'(voice_key[6:0]), 64'd39);
    chk("t1_vel0", 64'(voice_velocity[6:0]), 64'd100);
    chk("t1_trigs", 64'(trig_cnt - t0), 64'd1);
    chk("t1_count", 64'(active_count), 64'd1);
    send(8'h40); send(8'h50); idle(4);
    chk("t2_active", 64'(voice_active), 64'h03);
    chk("t2_key1", 64'(voice_key[13:7]), 64'd43);
    chk("t2_vel1", 64'(voice_velocity[13:7]), 64'd80);
    chk("t2_count", 64'(active_count), 64'd2);

    // retrigger, note-off with retention, velocity-0 note-on of released note
    do_reset();
    t0 = trig_cnt;
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3C); send(8'h20); idle(4);
    chk("t3_active", 64'(voice_active), 64'h01);
    chk("t3_vel0", 64'(voice_velocity[6:0]), 64'd32);
    chk("t3_trigs", 64'(trig_cnt - t0), 64'd2);
    send(8'h80); send(8'h3C); send(8'h00); idle(4);
    chk("t3_off_active", 64'(voice_active), 64'h00);
    chk("t3_off_key0", 64'(voice_key[6:0]), 64'd39);
    chk("t3_off_count", 64'(active_count), 64'd1);
    send(8'h90); send(8'h3C); send(8'h00); idle(4);
    chk("t3_v0_active", 64'(voice_active), 64'h00);

    // realtime byte inside a message; foreign status aborts
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(4);
    chk("t4_rt_active", 64'(voice_active), 64'h01);
    do_reset();
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h3C); send(8'h64); idle(4);
    chk("t4_cc_active", 64'(voice_active), 64'h00);

    // nine distinct notes into eight voices
    do_reset();
    d0 = drop_cnt;
    send(8'h90);
    for (int i = 0; i < 9; i++) begin
      b = 8'h30 + 8'(i);
      send(b); send(8'h40);
    end
    idle(4);
    chk("t5_active", 64'(voice_active), 64'hFF);
    chk("t5_count", 64'(active_count), 64'd8);
`ifdef VOICE_STEAL_EN
    chk("t5_drops", 64'(drop_cnt - d0), 64'd0);
    chk("t5_key0", 64'(voice_key[6:0]), 64'd35);
`else
    chk("t5_drops", 64'(drop_cnt - d0), 64'd1);
    chk("t5_key0", 64'(voice_key[6:0]), 64'd27);
    chk("t5_key7", 64'(voice_key[55:49]), 64'd34);
`endif

    // out-of-range note, then reset in mid-message
    do_reset();
    d0 = drop_cnt;
    send(8'h90); send(8'h10); send(8'h40); idle(4);
    chk("t6_oor_active", 64'(voice_active), 64'h00);
    chk("t6_oor_drops", 64'(drop_cnt - d0), 64'd0);
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    send(8'h90); send(8'h3D);
    do_reset();
    chk("t6_rst_active", 64'(voice_active), 64'h00);
    send(8'h64); idle(4);
    chk("t6_post_active", 64'(voice_active), 64'h00);
    chk("t6_post_count", 64'(active_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
